// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory write buffer.
// Holds the drain FSM state encoding and the alignment helper.
package dmem_pkg;

    localparam int unsigned DEFAULT_DEPTH = 4;
    localparam int unsigned DEFAULT_AW    = 64;
    localparam int unsigned DEFAULT_DW    = 64;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } drain_state_e;

    // Doublewords only: the low three address bits must be clear.
    function automatic logic dw_aligned(input logic [2:0] lsb);
        return (lsb == 3'b000);
    endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Circular store buffer with head/tail pointers, occupancy count and a
// parallel doubleword-address compare for store-to-load forwarding.
module wbuf_fifo
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = DEFAULT_AW,
    parameter int unsigned DW    = DEFAULT_DW,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [AW-1:0] i_push_addr,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output logic [AW-1:0] o_head_addr,
    output logic [DW-1:0] o_head_data,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty,
    input  logic [AW-4:0] i_rd_tag,
    output logic          o_rd_hit,
    output logic [DW-1:0] o_rd_data
);

    logic [AW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_idx;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    assign o_head_addr = r_addr[r_head];
    assign o_head_data = r_data[r_head];

    // Payload needs no reset: validity is tracked by pointers and count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= i_push_addr;
            r_data[r_tail] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Walk oldest to newest so the last match (newest store) wins.
    always_comb begin
        o_rd_hit  = 1'b0;
        o_rd_data = '0;
        w_idx     = r_head;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PW'(k);
            if ((CW'(k) < r_count) && (r_addr[w_idx][AW-1:3] == i_rd_tag)) begin
                o_rd_hit  = 1'b1;
                o_rd_data = r_data[w_idx];
            end
        end
    end

endmodule

// File: rtl/dmem_wbuf.sv
// Data-memory store responder: buffers core stores and drains them in order
// to backing memory over req/ack, with forwarding lookup and drained flag.
module dmem_wbuf
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = DEFAULT_AW,
    parameter int unsigned DW    = DEFAULT_DW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   memwrite,
    input  logic [AW-1:0]          address,
    input  logic [DW-1:0]          data,
    output logic                   stall,
    output logic                   mem_req,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    input  logic                   mem_ack,
    input  logic [AW-1:0]          rd_addr,
    output logic                   rd_hit,
    output logic [DW-1:0]          rd_data,
    output logic                   misalign,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drained
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    drain_state_e  r_state;
    logic          r_mem_req;
    logic          r_misalign;

    logic          w_aligned;
    logic          w_push;
    logic          w_pop;
    logic          w_more;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [AW-1:0] w_head_addr;
    logic [DW-1:0] w_head_data;
    logic          w_unused_rd_lsb;

    assign w_aligned = dw_aligned(address[2:0]);
    assign w_push    = memwrite && !w_full && w_aligned;
    assign w_pop     = r_mem_req && mem_ack;
    // Occupancy after this cycle's pop stays nonzero: keep requesting back-to-back.
    assign w_more    = (w_count > CW'(1)) || w_push;

    assign w_unused_rd_lsb = ^rd_addr[2:0];

    wbuf_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_addr (address),
        .i_push_data (data),
        .i_pop       (w_pop),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .i_rd_tag    (rd_addr[AW-1:3]),
        .o_rd_hit    (rd_hit),
        .o_rd_data   (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_state   <= REQ;
                        r_mem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ack && !w_more) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (memwrite && !w_aligned) begin
            r_misalign <= 1'b1;
        end
    end

    assign stall     = w_full;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_req ? w_head_addr : '0;
    assign mem_wdata = r_mem_req ? w_head_data : '0;
    assign misalign  = r_misalign;
    assign count     = w_count;
    assign drained   = w_empty && (r_state == IDLE);

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed self-checking bench for dmem_wbuf: drain latency, full/stall,
// forwarding, misalignment, wrap with concurrent push/pop, and mid-drain reset.
module tb_dmem_wbuf;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 64;
    localparam int unsigned DW    = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          memwrite;
    logic [AW-1:0] address;
    logic [DW-1:0] data;
    logic          stall;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [AW-1:0] rd_addr;
    logic          rd_hit;
    logic [DW-1:0] rd_data;
    logic          misalign;
    logic [2:0]    count;
    logic          drained;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] st_addr [8];
    logic [63:0] st_data [8];
    int unsigned exp_cnt [9];

    dmem_wbuf #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .memwrite  (memwrite),
        .address   (address),
        .data      (data),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .rd_addr   (rd_addr),
        .rd_hit    (rd_hit),
        .rd_data   (rd_data),
        .misalign  (misalign),
        .count     (count),
        .drained   (drained)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        memwrite = 1'b0;
        address  = '0;
        data     = '0;
        mem_ack  = 1'b0;
        rd_addr  = '0;
        tick();
        tick();

        // Reset state
        check("rst_count", 64'(count), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_drained", 64'(drained), 64'd1);
        check("rst_misalign", 64'(misalign), 64'd0);
        check("rst_rd_hit", 64'(rd_hit), 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        rst_n = 1'b1;
        tick();

        // Single store, ack tied high: req exactly two cycles later, one cycle long
        memwrite = 1'b1;
        address  = 64'h8000_0008;
        data     = 64'hDEAD_BEEF;
        mem_ack  = 1'b1;
        tick();
        memwrite = 1'b0;
        rd_addr  = 64'h8000_0008;
        #1;
        check("t1_count_n1", 64'(count), 64'd1);
        check("t1_req_n1", 64'(mem_req), 64'd0);
        check("t1_drained_n1", 64'(drained), 64'd0);
        check("t1_fwd_hit", 64'(rd_hit), 64'd1);
        check("t1_fwd_data", rd_data, 64'hDEAD_BEEF);
        tick();
        check("t1_req_n2", 64'(mem_req), 64'd1);
        check("t1_addr_n2", mem_addr, 64'h8000_0008);
        check("t1_wdata_n2", mem_wdata, 64'hDEAD_BEEF);
        tick();
        check("t1_req_n3", 64'(mem_req), 64'd0);
        check("t1_count_n3", 64'(count), 64'd0);
        check("t1_drained_n3", 64'(drained), 64'd1);
        mem_ack = 1'b0;
        tick();

        // Five stores, no ack: fifth dropped, then four back-to-back drains
        for (int i = 0; i < 5; i++) begin
            memwrite = 1'b1;
            address  = 64'h1000 + 64'(8 * i);
            data     = 64'h11 * 64'(i + 1);
            tick();
            if (i == 3) begin
                check("t2_stall_after4", 64'(stall), 64'd1);
            end
        end
        memwrite = 1'b0;
        check("t2_count_full", 64'(count), 64'd4);
        check("t2_req_held", 64'(mem_req), 64'd1);
        check("t2_head_held", mem_addr, 64'h1000);
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t2_req_%0d", i), 64'(mem_req), 64'd1);
            check($sformatf("t2_addr_%0d", i), mem_addr, 64'h1000 + 64'(8 * i));
            check($sformatf("t2_wdata_%0d", i), mem_wdata, 64'h11 * 64'(i + 1));
            tick();
        end
        check("t2_req_done", 64'(mem_req), 64'd0);
        check("t2_drained", 64'(drained), 64'd1);
        mem_ack = 1'b0;
        tick();

        // Forwarding: newest of two matching stores wins, miss reads zero
        memwrite = 1'b1;
        address  = 64'h100;
        data     = 64'hAAAA;
        tick();
        data     = 64'hBBBB;
        tick();
        memwrite = 1'b0;
        rd_addr  = 64'h104;
        #1;
        check("t3_count", 64'(count), 64'd2);
        check("t3_hit", 64'(rd_hit), 64'd1);
        check("t3_data_newest", rd_data, 64'hBBBB);
        rd_addr = 64'h108;
        #1;
        check("t3_miss_hit", 64'(rd_hit), 64'd0);
        check("t3_miss_data", rd_data, 64'd0);
        mem_ack = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        check("t3_count_drained", 64'(count), 64'd0);
        check("t3_drained", 64'(drained), 64'd1);
        tick();

        // Misaligned store rejected, flag sticky, aligned store still accepted
        memwrite = 1'b1;
        address  = 64'h103;
        data     = 64'h77;
        #1;
        check("t4_misalign_before", 64'(misalign), 64'd0);
        tick();
        memwrite = 1'b0;
        check("t4_count", 64'(count), 64'd0);
        check("t4_misalign_set", 64'(misalign), 64'd1);
        check("t4_no_req", 64'(mem_req), 64'd0);
        tick();
        check("t4_misalign_sticky", 64'(misalign), 64'd1);
        memwrite = 1'b1;
        address  = 64'h200;
        data     = 64'h99;
        tick();
        memwrite = 1'b0;
        check("t4_aligned_count", 64'(count), 64'd1);
        check("t4_misalign_still", 64'(misalign), 64'd1);
        mem_ack = 1'b1;
        tick();
        check("t4_req_addr", mem_addr, 64'h200);
        tick();
        check("t4_drained", 64'(drained), 64'd1);
        mem_ack = 1'b0;
        tick();

        // Full buffer, stall cycle, then push and ack together across pointer wrap
        for (int i = 0; i < 8; i++) begin
            st_addr[i] = 64'h300 + 64'(8 * i);
            st_data[i] = 64'hC0 + 64'(i);
        end
        exp_cnt = '{4, 3, 3, 3, 3, 3, 2, 1, 0};
        for (int i = 0; i < 4; i++) begin
            memwrite = 1'b1;
            address  = st_addr[i];
            data     = st_data[i];
            tick();
        end
        address = st_addr[4];
        data    = st_data[4];
        tick();
        check("t5_stall_cycle", 64'(stall), 64'd1);
        check("t5_count_stall", 64'(count), 64'd4);
        mem_ack = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (j <= 1) begin
                memwrite = 1'b1;
                address  = st_addr[4];
                data     = st_data[4];
            end else if (j <= 4) begin
                memwrite = 1'b1;
                address  = st_addr[j + 3];
                data     = st_data[j + 3];
            end else begin
                memwrite = 1'b0;
            end
            #1;
            check($sformatf("t5_count_%0d", j), 64'(count), 64'(exp_cnt[j]));
            check($sformatf("t5_req_%0d", j), 64'(mem_req), 64'd1);
            check($sformatf("t5_addr_%0d", j), mem_addr, st_addr[j]);
            check($sformatf("t5_wdata_%0d", j), mem_wdata, st_data[j]);
            tick();
        end
        check("t5_count_end", 64'(count), 64'(exp_cnt[8]));
        check("t5_req_end", 64'(mem_req), 64'd0);
        check("t5_drained", 64'(drained), 64'd1);
        mem_ack = 1'b0;
        tick();

        // Reset mid-drain with three entries queued
        for (int i = 0; i < 3; i++) begin
            memwrite = 1'b1;
            address  = 64'h400 + 64'(8 * i);
            data     = 64'hE0 + 64'(i);
            tick();
        end
        memwrite = 1'b0;
        check("t6_count_pre", 64'(count), 64'd3);
        check("t6_req_pre", 64'(mem_req), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_req_rst", 64'(mem_req), 64'd0);
        check("t6_count_rst", 64'(count), 64'd0);
        check("t6_drained_rst", 64'(drained), 64'd1);
        tick();
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        rd_addr = 64'h400;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t6_idle_req_%0d", i), 64'(mem_req), 64'd0);
            check($sformatf("t6_idle_count_%0d", i), 64'(count), 64'd0);
        end
        check("t6_no_fwd", 64'(rd_hit), 64'd0);
        memwrite = 1'b1;
        address  = 64'h500;
        data     = 64'hF00D;
        tick();
        memwrite = 1'b0;
        check("t6_req_new_n1", 64'(mem_req), 64'd0);
        tick();
        check("t6_req_new", 64'(mem_req), 64'd1);
        check("t6_addr_new", mem_addr, 64'h500);
        tick();
        check("t6_drained_end", 64'(drained), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
